// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter with broadcast:
// FSM states, packet ID extraction and destination-mask decoding.
package bus_pkg;

    localparam int MAX_DRVRS = 16;
    localparam int MAX_PKT   = 64;
    // Truncated to id_w at the point of use, giving an all-ones broadcast ID.
    localparam logic [31:0] BCAST_ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, POP, DLVR, DROP} state_t;

    function automatic logic [31:0] pkt_id(input logic [MAX_PKT-1:0] pkt,
                                           input int pkt_w, input int id_w);
        logic [31:0] msk;
        msk = (id_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << id_w) - 32'd1);
        return 32'(pkt >> (pkt_w - id_w)) & msk;
    endfunction

    // Broadcast reaches everyone but the sender; a unicast to self or to a
    // non-existent port yields an empty mask, which the caller treats as a drop.
    function automatic logic [MAX_DRVRS-1:0] target_mask(input logic [31:0] id,
                                                         input logic [3:0]  src,
                                                         input int          n,
                                                         input logic [31:0] bcast);
        logic [MAX_DRVRS-1:0] all_ports;
        logic [MAX_DRVRS-1:0] src_bit;
        all_ports = '0;
        for (int i = 0; i < MAX_DRVRS; i++)
            if (i < n) all_ports[i] = 1'b1;
        src_bit = MAX_DRVRS'(1) << src;
        if (id == bcast)
            return all_ports & ~src_bit;
        if (id < 32'(n) && id[3:0] != src)
            return MAX_DRVRS'(1) << id[3:0];
        return '0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first request found cyclically after ptr.
module rr_arbiter #(
    parameter int n     = 4,
    parameter int idx_w = 2
) (
    input  logic [n-1:0]     req,
    input  logic [idx_w-1:0] ptr,
    output logic [n-1:0]     gnt,
    output logic [idx_w-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [idx_w-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before any conditional write, so no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        // Walk from farthest to nearest so the nearest requester is written last and wins.
        for (int k = n; k >= 1; k--) begin
            cand = idx_w'((int'(ptr) + k) % n);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_vld)
            gnt = n'(1) << gnt_idx;
    end

endmodule

// File: rtl/bus_rr_arbiter_bcast.sv
// Shared-bus packet mover: round-robin pops from device FIFOs, unicast or
// broadcast delivery under per-receiver backpressure, timeout drops counted.
module bus_rr_arbiter_bcast
    import bus_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter int              id_w      = 8,
    parameter logic [id_w-1:0] broadcast = id_w'(BCAST_ALL_ONES),
    parameter int              tmo       = 16,
    parameter int              cnt_w     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    input  logic [drvrs-1:0]         full,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic                     busy,
    output logic [cnt_w-1:0]         drop_cnt,
    output logic                     err
);

    localparam int idx_w = $clog2(drvrs);
    localparam int tmo_w = $clog2(tmo + 1);

    state_t             state;
    logic [idx_w-1:0]   ptr;
    logic [idx_w-1:0]   g;
    logic [pckg_sz-1:0] pkt;
    logic [drvrs-1:0]   mask;
    logic [tmo_w-1:0]   wcnt;
    logic               sent;

    logic [drvrs-1:0]   arb_gnt;
    logic [idx_w-1:0]   arb_idx;
    logic               arb_vld;
    logic [pckg_sz-1:0] head;
    logic [31:0]        head_id;
    logic [drvrs-1:0]   head_mask;

    rr_arbiter #(.n(drvrs), .idx_w(idx_w)) u_rr (
        .req     (pndng),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign head      = D_pop[g*pckg_sz +: pckg_sz];
    assign head_id   = pkt_id(MAX_PKT'(head), pckg_sz, id_w);
    assign head_mask = drvrs'(target_mask(head_id, 4'(g), drvrs, 32'(broadcast)));

    always_ff @(posedge clk) begin
        // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
        if (reset) begin
            state    <= IDLE;
            ptr      <= idx_w'(drvrs - 1);
            g        <= '0;
            pkt      <= '0;
            mask     <= '0;
            wcnt     <= '0;
            sent     <= 1'b0;
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
            err      <= 1'b0;
        end else begin
            pop  <= '0;
            push <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: if (arb_vld) begin
                    g     <= arb_idx;
                    pop   <= arb_gnt;
                    busy  <= 1'b1;
                    state <= POP;
                end
                // Full is checked here too, so an unblocked packet pushes in the first DLVR cycle.
                POP: begin
                    pkt  <= head;
                    ptr  <= g;
                    mask <= head_mask;
                    wcnt <= '0;
                    sent <= 1'b0;
                    if (head_mask == '0) begin
                        err      <= 1'b1;
                        drop_cnt <= (drop_cnt == '1) ? drop_cnt : drop_cnt + 1'b1;
                        state    <= DROP;
                    end else begin
                        if ((head_mask & full) == '0) begin
                            push   <= head_mask;
                            D_push <= head;
                            sent   <= 1'b1;
                        end
                        state <= DLVR;
                    end
                end
                DLVR: begin
                    if (sent) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if ((mask & full) == '0) begin
                        push   <= mask;
                        D_push <= pkt;
                        sent   <= 1'b1;
                    end else if (wcnt == tmo_w'(tmo - 1)) begin
                        err      <= 1'b1;
                        drop_cnt <= (drop_cnt == '1) ? drop_cnt : drop_cnt + 1'b1;
                        state    <= DROP;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DROP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter_bcast.sv
// Scoreboard bench: stimulus queues expected pops and push/error events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_bus_rr_arbiter_bcast;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  pndng = '0;
    logic [3:0]  full  = '0;
    logic [63:0] d_pop = '0;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] d_push;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic        err;

    always #5 clk = ~clk;

    bus_rr_arbiter_bcast #(.drvrs(4), .pckg_sz(16), .id_w(8), .broadcast(8'hFF),
                           .tmo(16), .cnt_w(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .full     (full),
        .push     (push),
        .D_push   (d_push),
        .busy     (busy),
        .drop_cnt (drop_cnt),
        .err      (err)
    );

    typedef struct {
        logic        is_err;
        logic [3:0]  push;
        logic [15:0] data;
        logic [7:0]  dcnt;
    } ev_t;

    ev_t        out_q[$];
    logic [3:0] pop_q[$];
    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int last_pop_cyc = -100;
    int last_push_cyc = -100;
    int start_cyc = 0;
    int fall_cyc = 0;
    bit rr_mode = 1'b0;
    int rr_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pop and every push/err pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (pop != 4'b0000) begin
                if (pop_q.size() == 0) check("pop_unexpected", 32'(pop), 32'd0);
                else check("pop_order", 32'(pop), 32'(pop_q.pop_front()));
                if (rr_mode) begin
                    if (rr_seen > 0) check("rr_gap", cyc - last_pop_cyc, 32'd3);
                    rr_seen++;
                end
                last_pop_cyc = cyc;
            end
            if (push != 4'b0000 || err) begin
                ev_t e;
                if (out_q.size() == 0) begin
                    check("out_unexpected", 32'({err, push}), 32'd0);
                end else begin
                    e = out_q.pop_front();
                    check("err_flag", 32'(err), 32'(e.is_err));
                    if (e.is_err) begin
                        check("drop_cnt", 32'(drop_cnt), 32'(e.dcnt));
                    end else begin
                        check("push_mask", 32'(push), 32'(e.push));
                        check("d_push", 32'(d_push), 32'(e.data));
                    end
                end
                if (push != 4'b0000) last_push_cyc = cyc;
            end
        end
    end

    task automatic exp_push(input logic [3:0] m, input logic [15:0] data);
        ev_t e;
        e.is_err = 1'b0; e.push = m; e.data = data; e.dcnt = '0;
        out_q.push_back(e);
    endtask

    task automatic exp_err(input logic [7:0] dcnt);
        ev_t e;
        e.is_err = 1'b1; e.push = '0; e.data = '0; e.dcnt = dcnt;
        out_q.push_back(e);
    endtask

    task automatic wait_pop(input int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (pop[d]) ok = 1'b1;
        end
        check("pop_seen", 32'(ok), 32'd1);
    endtask

    // Device pops its FIFO at the edge that ends the POP cycle.
    task automatic send(input int d, input logic [15:0] data);
        pop_q.push_back(4'b0001 << d);
        d_pop[d*16 +: 16] = data;
        pndng[d] = 1'b1;
        start_cyc = cyc;
        wait_pop(d);
        @(posedge clk); #1;
        pndng[d] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_push", 32'(push), 32'd0);
        check("rst_d_push", 32'(d_push), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Round robin with all four devices pending: order 0,1,2,3,0,1,2,3.
        d_pop = {16'h00A3, 16'h03A2, 16'h02A1, 16'h01A0};
        for (int r = 0; r < 2; r++) begin
            pop_q.push_back(4'b0001); pop_q.push_back(4'b0010);
            pop_q.push_back(4'b0100); pop_q.push_back(4'b1000);
            exp_push(4'b0010, 16'h01A0); exp_push(4'b0100, 16'h02A1);
            exp_push(4'b1000, 16'h03A2); exp_push(4'b0001, 16'h00A3);
        end
        rr_mode = 1'b1;
        pndng = 4'b1111;
        for (int i = 0; i < 200 && rr_seen < 8; i++) @(negedge clk);
        @(posedge clk); #1;
        pndng = 4'b0000;
        rr_mode = 1'b0;
        check("rr_count", rr_seen, 32'd8);
        wait_idle();

        // Unicast with latency: pop one cycle after pndng, push one cycle after pop.
        exp_push(4'b0100, 16'h02AB);
        send(0, 16'h02AB);
        wait_idle();
        check("pop_latency", last_pop_cyc - start_cyc, 32'd1);
        check("push_latency", last_push_cyc - last_pop_cyc, 32'd1);
        check("drop_cnt_uni", 32'(drop_cnt), 32'd0);

        // Broadcast from device 1 reaches 0, 2 and 3 in a single push.
        exp_push(4'b1101, 16'hFF55);
        send(1, 16'hFF55);
        wait_idle();

        // Backpressure shorter than the timeout: push the cycle after full falls.
        full = 4'b1000;
        exp_push(4'b1000, 16'h0311);
        send(2, 16'h0311);
        check("busy_waiting", 32'(busy), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        full = 4'b0000;
        fall_cyc = cyc;
        wait_idle();
        check("push_after_fall", last_push_cyc - fall_cyc, 32'd1);

        // Backpressure past the timeout: dropped, counted, D_push holds last value.
        full = 4'b1000;
        exp_err(8'd1);
        send(2, 16'h0311);
        repeat (20) @(posedge clk);
        #1;
        full = 4'b0000;
        wait_idle();
        check("d_push_hold", 32'(d_push), 32'h0311);

        // Illegal destinations: out of range, then addressed to self.
        exp_err(8'd2);
        send(0, 16'h07CC);
        wait_idle();
        exp_err(8'd3);
        send(2, 16'h0200);
        wait_idle();
        check("drop_cnt_illegal", 32'(drop_cnt), 32'd3);

        // Reset while waiting in delivery discards the packet and restarts the pointer.
        full = 4'b0010;
        send(0, 16'h01EE);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        full = 4'b0000;
        @(negedge clk);
        check("mid_rst_pop", 32'(pop), 32'd0);
        check("mid_rst_push", 32'(push), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_d_push", 32'(d_push), 32'd0);

        pop_q.push_back(4'b0001);
        pop_q.push_back(4'b0010);
        exp_push(4'b0010, 16'h0122);
        exp_push(4'b0100, 16'h0233);
        d_pop[15:0]  = 16'h0122;
        d_pop[31:16] = 16'h0233;
        pndng = 4'b0011;
        wait_pop(0);
        @(posedge clk); #1;
        pndng[0] = 1'b0;
        wait_pop(1);
        @(posedge clk); #1;
        pndng[1] = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        check("pop_q_left", pop_q.size(), 32'd0);
        check("out_q_left", out_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
